// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single data_memory port. The core has priority, and a bounded-wait
// counter forces an aux grant. Define ARB_ROUND_ROBIN_EN to alternate grants on contention instead.
module data_mem_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  input  logic [3:0]            core_byteena,
  output logic                  core_stall,
  output logic                  core_rvalid,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  aux_req,
  input  logic                  aux_we,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic [DATA_WIDTH-1:0] aux_wdata,
  output logic                  aux_gnt,
  output logic                  aux_rvalid,
  output logic [DATA_WIDTH-1:0] aux_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  output logic [3:0]            mem_byteena,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  typedef enum logic {
    SIDE_CORE = 1'b0,
    SIDE_AUX  = 1'b1
  } side_e;

  logic       grant_core;
  logic       grant_aux;
  logic [1:0] rd_owner_q, rd_owner_d;  // bit 0 = core, bit 1 = aux

`ifdef ARB_ROUND_ROBIN_EN
  side_e rr_last_q, rr_last_d;

  // On contention the side that did not win last time wins now.
  always_comb begin
    grant_core = reset && core_req && (!aux_req || rr_last_q == SIDE_AUX);
    grant_aux  = reset && aux_req && (!core_req || rr_last_q == SIDE_CORE);
  end

  always_comb begin
    rr_last_d = rr_last_q;
    if (grant_core)     rr_last_d = SIDE_CORE;
    else if (grant_aux) rr_last_d = SIDE_AUX;
  end
`else
  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          force_aux;

  always_comb begin
    force_aux  = aux_req && (MAX_WAIT != 0) && (wait_cnt_q == CW'(MAX_WAIT));
    grant_core = reset && core_req && !force_aux;
    grant_aux  = reset && aux_req && (!core_req || force_aux);
  end

  // Counts consecutive refused aux cycles, saturating at MAX_WAIT.
  always_comb begin
    wait_cnt_d = '0;
    if (aux_req && !grant_aux)
      wait_cnt_d = (wait_cnt_q == CW'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + CW'(1);
  end
`endif

  // Grants are combinational because data_memory registers these inputs at the same edge.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    mem_byteena = 4'b0000;
    if (grant_core) begin
      mem_address = core_addr;
      mem_data    = core_wdata;
      mem_wren    = core_we;
      mem_byteena = core_byteena;
    end else if (grant_aux) begin
      mem_address = aux_addr;
      mem_data    = aux_wdata;
      mem_wren    = aux_we;
      mem_byteena = 4'b1111;
    end
  end

  always_comb begin
    rd_owner_d = {grant_aux && !aux_we, grant_core && !core_we};
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      rd_owner_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q  <= SIDE_AUX;
`else
      wait_cnt_q <= '0;
`endif
    end else begin
      rd_owner_q <= rd_owner_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q  <= rr_last_d;
`else
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign core_stall  = reset && core_req && !grant_core;
  assign aux_gnt     = grant_aux;
  assign core_rvalid = rd_owner_q[0];
  assign aux_rvalid  = rd_owner_q[1];
  assign core_rdata  = mem_q;
  assign aux_rdata   = mem_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized run against a behavioural model with its own memory image.
module tb_data_mem_arbiter;

  localparam int MW = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        core_req, core_we, aux_req, aux_we;
  logic [9:0]  core_addr, aux_addr;
  logic [31:0] core_wdata, aux_wdata;
  logic [3:0]  core_byteena;
  logic        core_stall, core_rvalid, aux_gnt, aux_rvalid, mem_wren;
  logic [31:0] core_rdata, aux_rdata, mem_data, mem_q;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteena;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  data_mem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MAX_WAIT(MW)) dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_byteena(core_byteena), .core_stall(core_stall), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_byteena(mem_byteena), .mem_q(mem_q)
  );

  // Environment memory: registered inputs, one-cycle read latency, byte-enabled writes.
  logic [31:0] env_mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] env_q, dir_q;
  logic        use_env;

  assign mem_q = use_env ? env_q : dir_q;

  always @(posedge clock) begin
    if (mem_wren)
      for (int b = 0; b < 4; b++)
        if (mem_byteena[b]) env_mem[mem_address][8*b +: 8] <= mem_data[8*b +: 8];
    env_q <= env_mem[mem_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_byteena = '0;
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = '0;
  endtask

  task automatic check_mem_idle(input string tag);
    check({tag, ".wren"}, mem_wren, 1'b0);
    check({tag, ".be"}, mem_byteena, 4'h0);
    check({tag, ".addr"}, mem_address, 10'h0);
    check({tag, ".data"}, mem_data, 32'h0);
  endtask

  // Reset with both sides requesting: everything must stay quiet, rvalid low afterwards.
  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    idle_inputs();
    core_req = 1'b1; core_we = 1'b1; core_addr = 10'h3FF; core_wdata = 32'hFFFF_FFFF;
    core_byteena = 4'hF; aux_req = 1'b1; aux_we = 1'b1; aux_addr = 10'h155;
    #1;
    check("rst.stall", core_stall, 1'b0);
    check("rst.gnt", aux_gnt, 1'b0);
    check_mem_idle("rst");
    @(negedge clock);
    reset = 1'b1;
    idle_inputs();
    #1;
    check("rst.crv", core_rvalid, 1'b0);
    check("rst.arv", aux_rvalid, 1'b0);
  endtask

  typedef struct {
    logic creq, cwe; logic [9:0] caddr; logic [31:0] cwd; logic [3:0] cbe;
    logic areq, awe; logic [9:0] aaddr; logic [31:0] awd;
    logic [31:0] q;
    logic e_stall, e_gnt, e_wren; logic [3:0] e_be; logic [9:0] e_addr; logic [31:0] e_data;
    logic e_crv, e_arv;
  } vec_t;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  vec_t vecs [9];

  // Model state for the randomized phase.
  int          refused;
  logic        rr_last_aux, exp_crv, exp_arv, eg_c, eg_a, force_a, core_hold, aux_hold;
  logic [31:0] exp_rd;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      env_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
      ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    end
    use_env = 1'b0;
    dir_q   = '0;
    reset   = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clock);

    apply_reset();

    // Each row: inputs, mem_q in that cycle, expected outputs (rvalid refers to the previous row).
    vecs[0] = '{N,N,10'h000,32'h0,4'h0,        N,N,10'h000,32'h0,        32'h0,
                N,N,N,4'h0,10'h000,32'h0,        N,N};
    vecs[1] = '{Y,N,10'h010,32'h0,4'hF,        N,N,10'h000,32'h0,        32'h0,
                N,N,N,4'hF,10'h010,32'h0,        N,N};
    vecs[2] = '{N,N,10'h000,32'h0,4'h0,        N,N,10'h000,32'h0,        32'hDEADBEEF,
                N,N,N,4'h0,10'h000,32'h0,        Y,N};
    vecs[3] = '{N,N,10'h000,32'h0,4'h0,        Y,Y,10'h3F0,32'h12345678, 32'h0,
                N,Y,Y,4'hF,10'h3F0,32'h12345678, N,N};
    vecs[4] = '{Y,Y,10'h055,32'hCAFEF00D,4'h3, N,N,10'h000,32'h0,        32'h0,
                N,N,Y,4'h3,10'h055,32'hCAFEF00D, N,N};
    vecs[5] = '{N,N,10'h000,32'h0,4'h0,        Y,N,10'h021,32'h0BADC0DE, 32'h0,
                N,Y,N,4'hF,10'h021,32'h0BADC0DE, N,N};
    vecs[6] = '{Y,N,10'h002,32'h77,4'hF,       Y,N,10'h033,32'h0,        32'h11112222,
                N,N,N,4'hF,10'h002,32'h77,       N,Y};
    vecs[7] = '{N,N,10'h000,32'h0,4'h0,        Y,N,10'h033,32'h0,        32'h33334444,
                N,Y,N,4'hF,10'h033,32'h0,        Y,N};
    vecs[8] = '{N,N,10'h000,32'h0,4'h0,        N,N,10'h000,32'h0,        32'h55556666,
                N,N,N,4'h0,10'h000,32'h0,        N,Y};

    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      core_req = vecs[i].creq; core_we = vecs[i].cwe; core_addr = vecs[i].caddr;
      core_wdata = vecs[i].cwd; core_byteena = vecs[i].cbe;
      aux_req = vecs[i].areq; aux_we = vecs[i].awe; aux_addr = vecs[i].aaddr;
      aux_wdata = vecs[i].awd; dir_q = vecs[i].q;
      #1;
      check($sformatf("vec%0d.stall", i), core_stall, vecs[i].e_stall);
      check($sformatf("vec%0d.gnt", i), aux_gnt, vecs[i].e_gnt);
      check($sformatf("vec%0d.wren", i), mem_wren, vecs[i].e_wren);
      check($sformatf("vec%0d.be", i), mem_byteena, vecs[i].e_be);
      check($sformatf("vec%0d.addr", i), mem_address, vecs[i].e_addr);
      check($sformatf("vec%0d.data", i), mem_data, vecs[i].e_data);
      check($sformatf("vec%0d.crv", i), core_rvalid, vecs[i].e_crv);
      check($sformatf("vec%0d.arv", i), aux_rvalid, vecs[i].e_arv);
      if (vecs[i].e_crv) check($sformatf("vec%0d.crdata", i), core_rdata, vecs[i].q);
      if (vecs[i].e_arv) check($sformatf("vec%0d.ardata", i), aux_rdata, vecs[i].q);
    end

    // Core read then aux read on consecutive cycles: rvalid follows each owner by one cycle.
    @(negedge clock);
    idle_inputs(); core_req = 1'b1; core_addr = 10'h004; core_byteena = 4'hF;
    #1 check("alt.c_addr", mem_address, 10'h004);
    @(negedge clock);
    idle_inputs(); aux_req = 1'b1; aux_addr = 10'h008; dir_q = 32'hA1A1_A1A1;
    #1;
    check("alt.a_gnt", aux_gnt, 1'b1);
    check("alt.a_addr", mem_address, 10'h008);
    check("alt.crv1", core_rvalid, 1'b1);
    check("alt.arv1", aux_rvalid, 1'b0);
    check("alt.crdata", core_rdata, 32'hA1A1_A1A1);
    @(negedge clock);
    idle_inputs(); dir_q = 32'hB2B2_B2B2;
    #1;
    check("alt.crv2", core_rvalid, 1'b0);
    check("alt.arv2", aux_rvalid, 1'b1);
    check("alt.ardata", aux_rdata, 32'hB2B2_B2B2);

`ifdef ARB_ROUND_ROBIN_EN
    // Continuous contention from reset alternates core, aux, core, aux.
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      core_req = 1'b1; core_addr = 10'h100; core_byteena = 4'hF;
      aux_req = 1'b1; aux_we = 1'b1; aux_addr = 10'h200;
      #1;
      check($sformatf("rr%0d.stall", c), core_stall, (c % 2) == 1);
      check($sformatf("rr%0d.gnt", c), aux_gnt, (c % 2) == 1);
    end
`else
    // Continuous contention: aux refused for MW cycles, forced on the next, then core again.
    apply_reset();
    for (int c = 0; c <= MW + 1; c++) begin
      @(negedge clock);
      core_req = 1'b1; core_addr = 10'h100; core_byteena = 4'hF;
      aux_req = 1'b1; aux_we = 1'b1; aux_addr = 10'h200; aux_wdata = 32'h0;
      #1;
      check($sformatf("force%0d.gnt", c), aux_gnt, c == MW);
      check($sformatf("force%0d.stall", c), core_stall, c == MW);
    end
`endif

    // Reset arriving right after a granted core read suppresses its rvalid and clears the counter.
    @(negedge clock);
    idle_inputs(); core_req = 1'b1; core_addr = 10'h040; core_byteena = 4'hF;
    #1 check("rmid.stall", core_stall, 1'b0);
    #2 reset = 1'b0;
    @(negedge clock);
    core_we = 1'b1; aux_req = 1'b1; aux_we = 1'b1; aux_addr = 10'h041;
    #1;
    check("rmid.crv", core_rvalid, 1'b0);
    check("rmid.gnt", aux_gnt, 1'b0);
    check("rmid.stall2", core_stall, 1'b0);
    check_mem_idle("rmid");
`ifndef ARB_ROUND_ROBIN_EN
    for (int c = 0; c <= MW; c++) begin
      @(negedge clock);
      reset = 1'b1;
      #1 check($sformatf("rmid%0d.gnt", c), aux_gnt, c == MW);
    end
`endif
    @(negedge clock);
    reset = 1'b1;
    idle_inputs();

    // Randomized traffic against the behavioural model; both memories start identical.
    apply_reset();
    use_env = 1'b1;
    refused = 0; rr_last_aux = 1'b1; exp_crv = 1'b0; exp_arv = 1'b0; exp_rd = '0;
    core_hold = 1'b0; aux_hold = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clock);
      if (!core_hold) begin
        core_req = ($urandom_range(0, 99) < 80); core_we = 1'($urandom_range(0, 1));
        core_addr = 10'($urandom_range(0, 15)); core_wdata = $urandom;
        core_byteena = 4'($urandom_range(0, 15));
      end
      if (!aux_hold) begin
        aux_req = ($urandom_range(0, 99) < 50); aux_we = 1'($urandom_range(0, 1));
        aux_addr = 10'($urandom_range(0, 15)); aux_wdata = $urandom;
      end
      #1;
`ifdef ARB_ROUND_ROBIN_EN
      force_a = 1'b0;
      eg_c = core_req && (!aux_req || rr_last_aux);
`else
      force_a = aux_req && (MW != 0) && (refused >= MW);
      eg_c = core_req && !force_a;
`endif
      eg_a = aux_req && !eg_c;
      check("rnd.stall", core_stall, core_req && !eg_c);
      check("rnd.gnt", aux_gnt, eg_a);
      check("rnd.wren", mem_wren, (eg_c && core_we) || (eg_a && aux_we));
      check("rnd.addr", mem_address, eg_c ? core_addr : (eg_a ? aux_addr : 10'h0));
      check("rnd.data", mem_data, eg_c ? core_wdata : (eg_a ? aux_wdata : 32'h0));
      check("rnd.be", mem_byteena, eg_c ? core_byteena : (eg_a ? 4'hF : 4'h0));
      check("rnd.crv", core_rvalid, exp_crv);
      check("rnd.arv", aux_rvalid, exp_arv);
      if (exp_crv) check("rnd.crdata", core_rdata, exp_rd);
      if (exp_arv) check("rnd.ardata", aux_rdata, exp_rd);
      exp_crv = eg_c && !core_we;
      exp_arv = eg_a && !aux_we;
      if (exp_crv) exp_rd = ref_mem[core_addr];
      if (exp_arv) exp_rd = ref_mem[aux_addr];
      if (eg_c && core_we)
        for (int b = 0; b < 4; b++)
          if (core_byteena[b]) ref_mem[core_addr][8*b +: 8] = core_wdata[8*b +: 8];
      if (eg_a && aux_we) ref_mem[aux_addr] = aux_wdata;
      refused = (aux_req && !eg_a) ? refused + 1 : 0;
      if (eg_c) rr_last_aux = 1'b0;
      else if (eg_a) rr_last_aux = 1'b1;
      core_hold = core_req && !eg_c;
      aux_hold  = aux_req && !eg_a;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
